hvgen_param: RTL and testbench

- Parametrised successor to the fixed 512-count H/V generator used by the SYS1 video path.
- Counts pixel-clock-enabled positions over a configurable raster and emits HPOS/VPOS for the tile/sprite engines.
- Produces registered blanking and active-low syncs, plus line/frame strobes, and a pipeline-aligned copy of the pixel colour.
- Sync offsets are runtime-adjustable, signed, and latched only at frame start, so sync never glitches mid-frame.

---
 rtl/hvgen_pkg.sv | 42 ++++
 rtl/hvgen_axis.sv | 85 ++++++++
 rtl/hvgen_param.sv | 141 ++++++++++++++
 tb/tb_hvgen_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hvgen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hvgen_pkg
// Brief    : Default SYS1 raster timing constants and the modulo-wrap helper
//            shared by the parametrised H/V generator.
// Revision : 1.0 - initial release
// ============================================================================
package hvgen_pkg;

    localparam int DEF_CW          = 15;
    localparam int DEF_H_TOTAL     = 384;
    localparam int DEF_H_ORIGIN    = 16;
    localparam int DEF_H_ACT_START = 30;
    localparam int DEF_H_ACT       = 256;
    localparam int DEF_H_TRIM      = 8;
    localparam int DEF_H_SYNC_BASE = 288;
    localparam int DEF_H_SYNC_W    = 32;
    localparam int DEF_H_OFFS_STEP = 2;
    localparam int DEF_V_TOTAL     = 262;
    localparam int DEF_V_ACT       = 224;
    localparam int DEF_V_SYNC_BASE = 226;
    localparam int DEF_V_SYNC_W    = 4;
    localparam int DEF_V_OFFS_STEP = 4;

    // Folds a value lying within one modulus either side of 0..mod-1 back into range.
    function automatic logic signed [10:0] mod_wrap(
        input logic signed [10:0] val,
        input logic signed [10:0] modulus
    );
        logic signed [10:0] r;
        r = val;
        if (r < 0) begin
            r = r + modulus;
        end else if (r >= modulus) begin
            r = r - modulus;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hvgen_axis.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hvgen_axis
// Brief    : One raster axis: position counter, frame-latched sync offset,
//            sync window and active window, with registered blank/sync.
// Revision : 1.0 - initial release
// ============================================================================
module hvgen_axis
    import hvgen_pkg::*;
#(
    parameter int TOTAL     = DEF_H_TOTAL,
    parameter int SYNC_BASE = DEF_H_SYNC_BASE,
    parameter int SYNC_W    = DEF_H_SYNC_W,
    parameter int OFFS_STEP = DEF_H_OFFS_STEP,
    parameter int OFFS_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              adv_i,
    input  logic              latch_i,
    input  logic [OFFS_W-1:0] offs_i,
    input  logic [8:0]        act_lo_i,
    input  logic [8:0]        act_hi_i,
    output logic [8:0]        cnt_o,
    output logic              last_o,
    output logic              blk_d_o,
    output logic              blk_o,
    output logic              sync_n_o
);

    localparam logic [8:0]         C_LAST    = 9'(TOTAL - 1);
    localparam logic signed [10:0] C_TOTAL   = 11'(TOTAL);
    localparam logic signed [10:0] C_BASE    = 11'(SYNC_BASE);
    localparam logic signed [10:0] C_STEP    = 11'(OFFS_STEP);
    localparam logic signed [10:0] C_SYNC_W  = 11'(SYNC_W);

    logic [8:0]         cnt_q;
    logic [8:0]         cnt_d;
    logic [OFFS_W-1:0]  offs_q;
    logic               blk_q;
    logic               sync_n_q;
    logic               sync_n_d;
    logic signed [10:0] w_offs_x;
    logic signed [10:0] w_start;
    logic signed [10:0] w_dist;

    always_comb begin
        last_o   = (cnt_q == C_LAST);
        cnt_d    = cnt_q;
        if (adv_i) begin
            cnt_d = last_o ? 9'd0 : cnt_q + 9'd1;
        end
        w_offs_x = {{(11 - OFFS_W){offs_q[OFFS_W-1]}}, offs_q};
        w_start  = mod_wrap(C_BASE + w_offs_x * C_STEP, C_TOTAL);
        // Distance past the sync start, wrapped so the window may straddle TOTAL.
        w_dist   = mod_wrap(signed'({2'b00, cnt_q}) - w_start, C_TOTAL);
        sync_n_d = !(w_dist < C_SYNC_W);
        blk_d_o  = !((cnt_q >= act_lo_i) && (cnt_q < act_hi_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 9'd0;
            offs_q   <= '0;
            blk_q    <= 1'b1;
            sync_n_q <= 1'b1;
        end else if (en_i) begin
            cnt_q    <= cnt_d;
            blk_q    <= blk_d_o;
            sync_n_q <= sync_n_d;
            // The window above still sees the old offset on the latching enable.
            if (latch_i) begin
                offs_q <= offs_i;
            end
        end
    end

    assign cnt_o    = cnt_q;
    assign blk_o    = blk_q;
    assign sync_n_o = sync_n_q;

endmodule
`default_nettype wire

// File: rtl/hvgen_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hvgen_param
// Brief    : Parametrised H/V raster generator with frame-latched signed sync
//            offsets. Define HVGEN_RGB_BLANK_EN to zero oRGB during blanking.
// Revision : 1.0 - initial release
// ============================================================================
module hvgen_param
    import hvgen_pkg::*;
#(
    parameter int CW          = DEF_CW,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_ORIGIN    = DEF_H_ORIGIN,
    parameter int H_ACT_START = DEF_H_ACT_START,
    parameter int H_ACT       = DEF_H_ACT,
    parameter int H_TRIM      = DEF_H_TRIM,
    parameter int H_SYNC_BASE = DEF_H_SYNC_BASE,
    parameter int H_SYNC_W    = DEF_H_SYNC_W,
    parameter int H_OFFS_STEP = DEF_H_OFFS_STEP,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_ACT       = DEF_V_ACT,
    parameter int V_SYNC_BASE = DEF_V_SYNC_BASE,
    parameter int V_SYNC_W    = DEF_V_SYNC_W,
    parameter int V_OFFS_STEP = DEF_V_OFFS_STEP
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          PCLK_EN,
    input  logic          H240,
    input  logic [5:0]    HOFFS,
    input  logic [4:0]    VOFFS,
    input  logic [CW-1:0] iRGB,
    output logic [8:0]    HPOS,
    output logic [8:0]    VPOS,
    output logic [CW-1:0] oRGB,
    output logic          HBLK,
    output logic          VBLK,
    output logic          HSYN,
    output logic          VSYN,
    output logic          LINE_STB,
    output logic          FRAME_STB
);

    localparam logic [8:0] C_H_A    = 9'(H_ACT_START);
    localparam logic [8:0] C_H_B    = 9'(H_ACT_START + H_ACT);
    localparam logic [8:0] C_H_TRIM = 9'(H_TRIM);
    localparam logic [8:0] C_V_ACT  = 9'(V_ACT);
    localparam logic [8:0] C_ORIGIN = 9'(H_ORIGIN);

    logic [8:0]    w_hcnt;
    logic [8:0]    w_vcnt;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_latch;
    logic [8:0]    w_h_lo;
    logic [8:0]    w_h_hi;
    logic          w_hblk_d;
    logic          w_vblk_d;
    logic [CW-1:0] rgb_d;
    logic [CW-1:0] rgb_q;
    logic          line_stb_q;
    logic          frame_stb_q;

    assign w_h_lo  = H240 ? (C_H_A + C_H_TRIM) : C_H_A;
    assign w_h_hi  = H240 ? (C_H_B - C_H_TRIM) : C_H_B;
    assign w_latch = w_h_last & w_v_last;

    hvgen_axis #(
        .TOTAL     (H_TOTAL),
        .SYNC_BASE (H_SYNC_BASE),
        .SYNC_W    (H_SYNC_W),
        .OFFS_STEP (H_OFFS_STEP),
        .OFFS_W    (6)
    ) u_h_axis (
        .clk      (CLK),
        .rst      (RESET),
        .en_i     (PCLK_EN),
        .adv_i    (1'b1),
        .latch_i  (w_latch),
        .offs_i   (HOFFS),
        .act_lo_i (w_h_lo),
        .act_hi_i (w_h_hi),
        .cnt_o    (w_hcnt),
        .last_o   (w_h_last),
        .blk_d_o  (w_hblk_d),
        .blk_o    (HBLK),
        .sync_n_o (HSYN)
    );

    // Vertical axis steps on the horizontal wrap, so VSYN moves only at line boundaries.
    hvgen_axis #(
        .TOTAL     (V_TOTAL),
        .SYNC_BASE (V_SYNC_BASE),
        .SYNC_W    (V_SYNC_W),
        .OFFS_STEP (V_OFFS_STEP),
        .OFFS_W    (5)
    ) u_v_axis (
        .clk      (CLK),
        .rst      (RESET),
        .en_i     (PCLK_EN),
        .adv_i    (w_h_last),
        .latch_i  (w_latch),
        .offs_i   (VOFFS),
        .act_lo_i (9'd0),
        .act_hi_i (C_V_ACT),
        .cnt_o    (w_vcnt),
        .last_o   (w_v_last),
        .blk_d_o  (w_vblk_d),
        .blk_o    (VBLK),
        .sync_n_o (VSYN)
    );

`ifdef HVGEN_RGB_BLANK_EN
    assign rgb_d = (w_hblk_d | w_vblk_d) ? '0 : iRGB;
`else
    assign rgb_d = iRGB;
    logic w_unused_blk;
    assign w_unused_blk = &{1'b0, w_hblk_d, w_vblk_d};
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            line_stb_q  <= 1'b0;
            frame_stb_q <= 1'b0;
            rgb_q       <= '0;
        end else if (PCLK_EN) begin
            line_stb_q  <= (w_hcnt == 9'd0);
            frame_stb_q <= (w_hcnt == 9'd0) && (w_vcnt == 9'd0);
            rgb_q       <= rgb_d;
        end
    end

    assign HPOS      = w_hcnt - C_ORIGIN;
    assign VPOS      = w_vcnt;
    assign oRGB      = rgb_q;
    assign LINE_STB  = line_stb_q;
    assign FRAME_STB = frame_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_hvgen_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hvgen_param
// Brief    : Directed self-checking bench for hvgen_param; horizontal timing at
//            SYS1 defaults, vertical raster shortened to 64 lines.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hvgen_param;

    localparam int HT   = 384;
    localparam int VT   = 64;
    localparam int VACT = 48;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PCLK_EN = 1'b0;
    logic        H240 = 1'b0;
    logic [5:0]  HOFFS = 6'd0;
    logic [4:0]  VOFFS = 5'd0;
    logic [14:0] iRGB = 15'd0;
    logic [8:0]  HPOS;
    logic [8:0]  VPOS;
    logic [14:0] oRGB;
    logic        HBLK, VBLK, HSYN, VSYN, LINE_STB, FRAME_STB;

    hvgen_param #(
        .CW(15), .H_TOTAL(HT), .H_ORIGIN(16), .H_ACT_START(30), .H_ACT(256),
        .H_TRIM(8), .H_SYNC_BASE(288), .H_SYNC_W(32), .H_OFFS_STEP(2),
        .V_TOTAL(VT), .V_ACT(VACT), .V_SYNC_BASE(50), .V_SYNC_W(4), .V_OFFS_STEP(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .H240(H240),
        .HOFFS(HOFFS), .VOFFS(VOFFS), .iRGB(iRGB), .HPOS(HPOS), .VPOS(VPOS),
        .oRGB(oRGB), .HBLK(HBLK), .VBLK(VBLK), .HSYN(HSYN), .VSYN(VSYN),
        .LINE_STB(LINE_STB), .FRAME_STB(FRAME_STB)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int h_m, v_m, dh, dv, n_en, last_fs, ls_clk;
    int blk_cnt, blk_min, blk_max, hs_cnt, hs_min, hs_max;
    int vs_arr[VT];
    int vb_arr[VT];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] rgb_pat(input int h, input int v);
        return 15'((v % 64) * 512 + h);
    endfunction

    task automatic clr_stats();
        blk_cnt = 0; blk_min = 9999; blk_max = -1;
        hs_cnt  = 0; hs_min  = 9999; hs_max  = -1;
    endtask

    task automatic step(input bit en);
        int exp_rgb;
        PCLK_EN = en;
        iRGB    = en ? rgb_pat(h_m, v_m) : ~iRGB;
        @(posedge CLK);
        #1;
        if (LINE_STB) ls_clk++;
        if (en) begin
            dh = h_m;
            dv = v_m;
            n_en++;
            if (h_m == HT - 1) begin
                h_m = 0;
                v_m = (v_m == VT - 1) ? 0 : v_m + 1;
            end else begin
                h_m = h_m + 1;
            end
            if (LINE_STB || dh == 0)
                check("line_stb", LINE_STB, int'(dh == 0));
            if (FRAME_STB || (dh == 0 && dv == 0))
                check("frame_stb", FRAME_STB, int'(dh == 0 && dv == 0));
            if (FRAME_STB) begin
                if (last_fs >= 0) check("frame_period", n_en - last_fs, HT * VT);
                last_fs = n_en;
            end
            if (dh == 0) begin
                check("hpos", HPOS, (h_m - 16) & 'h1FF);
                check("vpos", VPOS, v_m);
            end
            if (dh == 5 || dh == 100) begin
                exp_rgb = rgb_pat(dh, dv);
`ifdef HVGEN_RGB_BLANK_EN
                if (dh == 5 || dv >= VACT) exp_rgb = 0;
`endif
                check("orgb", oRGB, exp_rgb);
            end
            if (!HBLK) begin
                blk_cnt++;
                if (dh < blk_min) blk_min = dh;
                if (dh > blk_max) blk_max = dh;
            end
            if (!HSYN) begin
                hs_cnt++;
                if (dh < hs_min) hs_min = dh;
                if (dh > hs_max) hs_max = dh;
            end
            vs_arr[dv] = VSYN;
            vb_arr[dv] = VBLK;
        end
    endtask

    task automatic run_line();
        clr_stats();
        for (int i = 0; i < HT; i++) step(1'b1);
    endtask

    task automatic run_lines(input int n);
        for (int i = 0; i < n; i++) run_line();
    endtask

    task automatic check_hs(input string tag, input int mn, input int mx);
        check({tag, "_hs_min"}, hs_min, mn);
        check({tag, "_hs_max"}, hs_max, mx);
        check({tag, "_hs_cnt"}, hs_cnt, 32);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hpos"}, HPOS, 'h1F0);
        check({tag, "_vpos"}, VPOS, 0);
        check({tag, "_hblk"}, HBLK, 1);
        check({tag, "_vblk"}, VBLK, 1);
        check({tag, "_hsyn"}, HSYN, 1);
        check({tag, "_vsyn"}, VSYN, 1);
        check({tag, "_lstb"}, LINE_STB, 0);
        check({tag, "_fstb"}, FRAME_STB, 0);
        check({tag, "_orgb"}, oRGB, 0);
    endtask

    initial begin
        logic [8:0]  hp;
        logic        ls;
        logic [14:0] rg;
        h_m = 0; v_m = 0; n_en = 0; last_fs = -1; ls_clk = 0;
        clr_stats();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check_reset_vals("por");

        // Advance to hcnt 100 / vcnt 50, then reset mid-frame with enable high.
        run_lines(50);
        for (int i = 0; i < 100; i++) step(1'b1);
        check("midframe_hpos", HPOS, 84);
        check("midframe_vpos", VPOS, 50);
        RESET   = 1'b1;
        PCLK_EN = 1'b1;
        @(posedge CLK);
        #1;
        RESET   = 1'b0;
        PCLK_EN = 1'b0;
        h_m = 0; v_m = 0; last_fs = -1;
        check_reset_vals("rst");
        repeat (3) step(1'b0);
        check_reset_vals("rst_hold");

        // Frame 0: wide line, narrow line, mid-frame HOFFS change.
        clr_stats();
        step(1'b1);
        check("first_hpos", HPOS, 'h1F1);
        check("first_hblk", HBLK, 1);
        check("first_vblk", VBLK, 0);
        check("first_hsyn", HSYN, 1);
        check("first_vsyn", VSYN, 1);
        for (int i = 1; i < HT; i++) step(1'b1);
        check("wide_blk_cnt", blk_cnt, 256);
        check("wide_blk_min", blk_min, 30);
        check("wide_blk_max", blk_max, 285);
        check_hs("wide", 288, 319);

        H240 = 1'b1;
        run_line();
        check("narrow_blk_cnt", blk_cnt, 240);
        check("narrow_blk_min", blk_min, 38);
        check("narrow_blk_max", blk_max, 277);
        H240 = 1'b0;

        HOFFS = 6'(-20);
        run_line();
        check_hs("hoffs_pending", 288, 319);
        VOFFS = 5'd4;
        run_lines(VT - 3);
        check("f0_vsyn_49", vs_arr[49], 1);
        check("f0_vsyn_50", vs_arr[50], 0);
        check("f0_vsyn_53", vs_arr[53], 0);
        check("f0_vsyn_54", vs_arr[54], 1);
        check("f0_vblk_47", vb_arr[47], 0);
        check("f0_vblk_48", vb_arr[48], 1);

        // Frame 1: HOFFS -20 and VOFFS +4 now in force.
        run_line();
        check_hs("hoffs_neg", 248, 279);
        HOFFS = 6'd30;
        run_line();
        check_hs("hoffs_neg_hold", 248, 279);
        run_lines(VT - 2);
        check("f1_vsyn_1", vs_arr[1], 1);
        check("f1_vsyn_2", vs_arr[2], 0);
        check("f1_vsyn_5", vs_arr[5], 0);
        check("f1_vsyn_6", vs_arr[6], 1);
        check("f1_vsyn_50", vs_arr[50], 1);

        // Frame 2: HOFFS +30, then a line at half enable rate.
        run_line();
        check_hs("hoffs_pos", 348, 379);

        clr_stats();
        ls_clk = 0;
        for (int i = 0; i < HT; i++) begin
            step(1'b1);
            hp = HPOS;
            ls = LINE_STB;
            rg = oRGB;
            step(1'b0);
            if (dh == 0 || dh == 100) begin
                check("hold_hpos", HPOS, hp);
                check("hold_lstb", LINE_STB, ls);
                check("hold_orgb", oRGB, rg);
            end
        end
        check("half_lstb_clocks", ls_clk, 2);
        check("half_blk_cnt", blk_cnt, 256);
        check_hs("half", 348, 379);
        check("half_end_hpos", HPOS, 'h1F0);
        check("half_end_vpos", VPOS, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
